// File: rtl/mux_scan_ctrl.sv
// Steps a 4:1 mux through channels 0..3, waits DWELL cycles per channel, then samples y into a 4-bit word.
// Latency: start accepted at cycle T gives done at T+1+4*(DWELL+1); data changes only on the edge entering DONE.
// Backpressure: none; start is honoured only while idle and is never queued.
module mux_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int CONT  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic       done,
    output logic [3:0] data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] shadow_q, shadow_d;
    logic [3:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= 2'd0;
            cnt_q    <= 8'd0;
            shadow_q <= 3'd0;
            data_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        case (state_q)
            IDLE: begin
                sel_d = 2'd0;
                cnt_d = 8'd0;
                if (start) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == DWELL_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                cnt_d = 8'd0;
                // Channels 0..2 park in the shadow so data only ever sees a full scan.
                case (sel_q)
                    2'd0: shadow_d[0] = y;
                    2'd1: shadow_d[1] = y;
                    2'd2: shadow_d[2] = y;
                    default: data_d = {y, shadow_q};
                endcase
                if (sel_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    sel_d   = sel_q + 2'd1;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                sel_d   = 2'd0;
                cnt_d   = 8'd0;
                state_d = (CONT != 0) ? SETTLE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s1   = sel_q[1];
    assign s0   = sel_q[0];
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign data = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Three scan controllers (DWELL 4/1/2, CONT 0/0/1) checked every cycle against a scan-position model,
// with directed scenarios pinning latency, data, reset and restart behaviour.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v, start_v, y_v;
    logic [2:0] s1_v, s0_v, busy_v, done_v;
    logic [3:0] data_v [3];

    mux_scan_ctrl #(.DWELL(4), .CONT(0)) u_a (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .y(y_v[0]),
        .s1(s1_v[0]), .s0(s0_v[0]), .busy(busy_v[0]), .done(done_v[0]), .data(data_v[0]));
    mux_scan_ctrl #(.DWELL(1), .CONT(0)) u_b (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .y(y_v[1]),
        .s1(s1_v[1]), .s0(s0_v[1]), .busy(busy_v[1]), .done(done_v[1]), .data(data_v[1]));
    mux_scan_ctrl #(.DWELL(2), .CONT(1)) u_c (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .y(y_v[2]),
        .s1(s1_v[2]), .s0(s0_v[2]), .busy(busy_v[2]), .done(done_v[2]), .data(data_v[2]));

    // pos = 0 when idle, otherwise cycles since the scan began; pos == scan_len is the DONE cycle.
    int         pos [3];
    logic [3:0] data_m [3];
    logic [2:0] shadow_m [3];
    logic [3:0] mux_in [3];
    logic [2:0] noise_en;
    int         cyc = 0;
    bit         chk_en = 1'b0;
    int         checks = 0;
    int         failures = 0;

    function automatic int dw(int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : 2;
    endfunction

    function automatic bit ct(int i);
        return (i == 2);
    endfunction

    function automatic int scan_len(int i);
        return 4 * (dw(i) + 1) + 1;
    endfunction

    function automatic bit is_sample(int i);
        return pos[i] >= 1 && pos[i] < scan_len(i) && ((pos[i] - 1) % (dw(i) + 1)) == dw(i);
    endfunction

    function automatic int exp_sel(int i);
        if (pos[i] == 0) return 0;
        if (pos[i] == scan_len(i)) return 3;
        return (pos[i] - 1) / (dw(i) + 1);
    endfunction

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        int ch;
        cyc = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (rst_v[i]) begin
                pos[i] = 0;
                data_m[i] = 4'd0;
                shadow_m[i] = 3'd0;
            end else if (pos[i] == 0) begin
                if (start_v[i]) pos[i] = 1;
            end else if (pos[i] == scan_len(i)) begin
                pos[i] = ct(i) ? 1 : 0;
            end else begin
                ch = (pos[i] - 1) / (dw(i) + 1);
                if (is_sample(i)) begin
                    if (ch < 3) shadow_m[i][ch] = y_v[i];
                    else data_m[i] = {y_v[i], shadow_m[i]};
                end
                pos[i] = pos[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("sel%0d", i), int'({s1_v[i], s0_v[i]}), exp_sel(i));
                check($sformatf("busy%0d", i), int'(busy_v[i]), int'(pos[i] != 0));
                check($sformatf("done%0d", i), int'(done_v[i]), int'(pos[i] == scan_len(i)));
                check($sformatf("data%0d", i), int'(data_v[i]), int'(data_m[i]));
            end
        end
    end

    // Downstream mux; with noise enabled y is random except in the model's sample cycles.
    always @(negedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (noise_en[i] && !is_sample(i)) y_v[i] = 1'($urandom_range(0, 1));
            else y_v[i] = mux_in[i][{s1_v[i], s0_v[i]}];
        end
    end

    initial begin
        int t0, d0, d1, n, last, found;
        logic [3:0] pat;
        rst_v = 3'b111;
        start_v = 3'b000;
        y_v = 3'b000;
        noise_en = 3'b000;
        for (int i = 0; i < 3; i++) begin
            pos[i] = 0; data_m[i] = 4'd0; shadow_m[i] = 3'd0; mux_in[i] = 4'd0;
        end
        repeat (2) @(negedge clk);
        rst_v = 3'b000;
        chk_en = 1'b1;
        check("rst_data", int'(data_v[0]), 0);
        check("rst_sel", int'({s1_v[0], s0_v[0]}), 0);
        check("rst_busy", int'(busy_v[0]), 0);

        // Fixed inputs 1,0,1,0 on the DWELL=4 unit; all ones on the DWELL=1 unit.
        mux_in[0] = 4'b0101;
        mux_in[1] = 4'b1111;
        start_v[1:0] = 2'b11;
        t0 = cyc; d0 = -1; d1 = -1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            start_v[1:0] = 2'b00;
            if (k == 6)  check("a_sel_ch1", int'({s1_v[0], s0_v[0]}), 1);
            if (k == 11) check("a_sel_ch2", int'({s1_v[0], s0_v[0]}), 2);
            if (k == 22) check("a_busy_low", int'(busy_v[0]), 0);
            if (done_v[0] && d0 < 0) d0 = cyc;
            if (done_v[1] && d1 < 0) d1 = cyc;
        end
        check("a_done_lat", d0 - t0, 21);
        check("a_data", int'(data_v[0]), 4'b0101);
        check("b_done_lat", d1 - t0, 9);
        check("b_data", int'(data_v[1]), 4'b1111);

        // Reset in the middle of channel 2.
        mux_in[0] = 4'b1111;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        found = 0;
        for (int k = 0; k < 30; k++) begin
            if ({s1_v[0], s0_v[0]} == 2'd2) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("r_reach_sel2", found, 1);
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        check("r_sel", int'({s1_v[0], s0_v[0]}), 0);
        check("r_busy", int'(busy_v[0]), 0);
        check("r_data", int'(data_v[0]), 0);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done_v[0]) n++;
        end
        check("r_no_done", n, 0);

        // start held high, y noisy outside sample cycles: one done per 22 cycles.
        noise_en[0] = 1'b1;
        mux_in[0] = 4'b0110;
        start_v[0] = 1'b1;
        t0 = cyc; n = 0; d0 = -1; last = -1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (done_v[0]) begin
                if (d0 < 0) d0 = cyc;
                else check("h_period", cyc - last, 22);
                last = cyc;
                n++;
                check("h_data", int'(data_v[0]), 4'b0110);
            end
        end
        check("h_first_lat", d0 - t0, 21);
        check("h_done_count", n, 3);
        start_v[0] = 1'b0;
        found = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!busy_v[0]) begin
                found = 1;
                break;
            end
        end
        check("h_returns_idle", found, 1);
        noise_en[0] = 1'b0;

        // Continuous mode, DWELL=2: done every 13 cycles, data follows input changes between scans.
        noise_en[2] = 1'b1;
        pat = 4'b1001;
        mux_in[2] = pat;
        start_v[2] = 1'b1;
        t0 = cyc; n = 0; d0 = -1; last = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start_v[2] = 1'b0;
            if (done_v[2]) begin
                if (d0 < 0) d0 = cyc;
                else check("c_period", cyc - last, 13);
                last = cyc;
                n++;
                check("c_data", int'(data_v[2]), int'(pat));
                pat = pat ^ 4'b0111;
                mux_in[2] = pat;
            end
        end
        check("c_first_lat", d0 - t0, 13);
        check("c_done_count", n, 4);
        rst_v[2] = 1'b1;
        @(negedge clk);
        rst_v[2] = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy_v[2]) n++;
        end
        check("c_idle_after_rst", n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
